// File: rtl/serial_adder_unit.sv
// Bit-serial add/subtract unit that drives one full-adder cell per clock, LSB first.
// Define SERIAL_ADDER_FLAGS_EN to add the registered zero/sign/overflow status ports.
module serial_adder_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             sub_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
`ifdef SERIAL_ADDER_FLAGS_EN
   output logic             zero_o,
   output logic             sign_o,
   output logic             overflow_o,
`endif
   output logic             carry_out_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shiftA_q, shiftA_d;
   logic [WIDTH-1:0] shiftB_q, shiftB_d;
   logic [WIDTH-1:0] accum_q, accum_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CW-1:0]    count_q, count_d;
   logic             carry_q, carry_d;
   logic             carryOut_q, carryOut_d;
   logic             sumBit;
   logic             coutBit;
   logic [WIDTH-1:0] nextAccum;

`ifdef SERIAL_ADDER_FLAGS_EN
   logic zero_q, zero_d;
   logic sign_q, sign_d;
   logic overflow_q, overflow_d;
`endif

   // The single full-adder cell shared by every bit position.
   always_comb begin
      sumBit    = shiftA_q[0] ^ shiftB_q[0] ^ carry_q;
      coutBit   = (shiftA_q[0] & shiftB_q[0]) | (carry_q & (shiftA_q[0] ^ shiftB_q[0]));
      nextAccum = {sumBit, accum_q[WIDTH-1:1]};
   end

   // Next-state logic; subtraction is a + ~b with the carry flop preset to 1.
   always_comb begin
      state_d    = state_q;
      shiftA_d   = shiftA_q;
      shiftB_d   = shiftB_q;
      accum_d    = accum_q;
      result_d   = result_q;
      count_d    = count_q;
      carry_d    = carry_q;
      carryOut_d = carryOut_q;
`ifdef SERIAL_ADDER_FLAGS_EN
      zero_d     = zero_q;
      sign_d     = sign_q;
      overflow_d = overflow_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_i) begin
               shiftA_d = a_i;
               shiftB_d = sub_i ? ~b_i : b_i;
               carry_d  = sub_i;
               count_d  = '0;
               accum_d  = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            accum_d  = nextAccum;
            shiftA_d = {1'b0, shiftA_q[WIDTH-1:1]};
            shiftB_d = {1'b0, shiftB_q[WIDTH-1:1]};
            carry_d  = coutBit;
            count_d  = count_q + CW'(1);
            if (count_q == LAST_BIT) begin
               result_d   = nextAccum;
               carryOut_d = coutBit;
`ifdef SERIAL_ADDER_FLAGS_EN
               // On the last bit, SA[0]/SB[0] are the operand MSBs and sumBit is the result MSB.
               zero_d     = (nextAccum == '0);
               sign_d     = sumBit;
               overflow_d = (shiftA_q[0] == shiftB_q[0]) && (sumBit != shiftA_q[0]);
`endif
               state_d    = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         shiftA_q   <= '0;
         shiftB_q   <= '0;
         accum_q    <= '0;
         result_q   <= '0;
         count_q    <= '0;
         carry_q    <= 1'b0;
         carryOut_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shiftA_q   <= shiftA_d;
         shiftB_q   <= shiftB_d;
         accum_q    <= accum_d;
         result_q   <= result_d;
         count_q    <= count_d;
         carry_q    <= carry_d;
         carryOut_q <= carryOut_d;
      end
   end

`ifdef SERIAL_ADDER_FLAGS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_q     <= 1'b0;
         sign_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         zero_q     <= zero_d;
         sign_q     <= sign_d;
         overflow_q <= overflow_d;
      end
   end

   assign zero_o     = zero_q;
   assign sign_o     = sign_q;
   assign overflow_o = overflow_q;
`endif

   assign busy_o      = (state_q == RUN);
   assign done_o      = (state_q == DONE);
   assign result_o    = result_q;
   assign carry_out_o = carryOut_q;

endmodule
